bp_cac_io_csr_endpoint: RTL and testbench

//  Terminates the uncached I/O command stream from the coherent-accelerator socket and returns I/O responses.

---
 rtl/bp_cac_io_csr_endpoint_if.sv | 61 ++++++
 rtl/bp_cac_io_csr_endpoint.sv | 199 +++++++++++++++++++
 tb/tb_bp_cac_io_csr_endpoint.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bp_cac_io_csr_endpoint_if.sv
// Shared message types and the I/O + job bus bundle for the accelerator CSR endpoint.

package bp_cac_io_csr_endpoint_pkg;

  // Processor configuration widths (inverted-cache configuration).
  localparam int unsigned paddr_width_gp     = 40;
  localparam int unsigned dword_width_gp     = 64;
  localparam int unsigned cce_block_width_gp = 512;
  localparam int unsigned payload_width_gp   = 16;
  localparam int unsigned msg_type_width_gp  = 4;
  localparam int unsigned msg_size_width_gp  = 3;

  // CCE memory message types.
  localparam logic [msg_type_width_gp-1:0] e_cce_mem_rd    = 4'b0000;
  localparam logic [msg_type_width_gp-1:0] e_cce_mem_wr    = 4'b0001;
  localparam logic [msg_type_width_gp-1:0] e_cce_mem_uc_rd = 4'b0010;
  localparam logic [msg_type_width_gp-1:0] e_cce_mem_wb    = 4'b0011;
  localparam logic [msg_type_width_gp-1:0] e_cce_mem_uc_wr = 4'b0100;

  // I/O command / response message.
  typedef struct packed {
    logic [cce_block_width_gp-1:0] data;
    logic [payload_width_gp-1:0]   payload;
    logic [msg_size_width_gp-1:0]  size;
    logic [paddr_width_gp-1:0]     addr;
    logic [msg_type_width_gp-1:0]  msg_type;
  } bp_cce_mem_msg_s;

endpackage

// I/O command/response and job launch signals between socket, endpoint and datapath.
interface bp_cac_io_csr_endpoint_if #(
  parameter int unsigned len_width_p = 16
);

  bp_cac_io_csr_endpoint_pkg::bp_cce_mem_msg_s io_cmd_i;
  logic                                        io_cmd_v_i;
  logic                                        io_cmd_ready_o;
  bp_cac_io_csr_endpoint_pkg::bp_cce_mem_msg_s io_resp_o;
  logic                                        io_resp_v_o;
  logic                                        io_resp_yumi_i;
  logic [bp_cac_io_csr_endpoint_pkg::paddr_width_gp-1:0] job_addr_o;
  logic [len_width_p-1:0]                      job_len_o;
  logic                                        job_v_o;
  logic                                        job_ready_i;
  logic                                        done_i;
  logic                                        busy_o;

  // Endpoint side.
  modport slave (
    input  io_cmd_i, io_cmd_v_i, io_resp_yumi_i, job_ready_i, done_i,
    output io_cmd_ready_o, io_resp_o, io_resp_v_o, job_addr_o, job_len_o, job_v_o, busy_o
  );

  // Socket / datapath side.
  modport master (
    output io_cmd_i, io_cmd_v_i, io_resp_yumi_i, job_ready_i, done_i,
    input  io_cmd_ready_o, io_resp_o, io_resp_v_o, job_addr_o, job_len_o, job_v_o, busy_o
  );

endinterface

// File: rtl/bp_cac_io_csr_endpoint.sv
// Uncached I/O CSR endpoint for the accelerator tile: decodes I/O commands into
// the CSR window, launches one datapath job at a time and times it until done.

module bp_cac_io_csr_endpoint
  import bp_cac_io_csr_endpoint_pkg::*;
#(
  parameter logic [paddr_width_gp-1:0] csr_base_addr_p = 40'h00_0020_0000,
  parameter int unsigned               len_width_p     = 16,
  parameter int unsigned               cnt_width_p     = 32
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  bp_cac_io_csr_endpoint_if.slave  io
);

  localparam int unsigned paddr_width_lp = paddr_width_gp;
  localparam int unsigned dword_width_lp = dword_width_gp;
  localparam int unsigned block_width_lp = cce_block_width_gp;

  localparam logic [7:0] start_off_lp  = 8'h00;
  localparam logic [7:0] src_off_lp    = 8'h08;
  localparam logic [7:0] len_off_lp    = 8'h10;
  localparam logic [7:0] status_off_lp = 8'h18;
  localparam logic [7:0] cycles_off_lp = 8'h20;

  typedef enum logic {
    e_ready,
    e_resp
  } state_e;

  state_e                    state_q, state_d;
  logic                      cmd_ready_q, cmd_ready_d;
  bp_cce_mem_msg_s           resp_q, resp_d;
  logic                      resp_v_q, resp_v_d;
  logic [paddr_width_lp-1:0] src_addr_q, src_addr_d;
  logic [len_width_p-1:0]    len_q, len_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;
  logic [cnt_width_p-1:0]    cycles_q, cycles_d;
  logic                      job_v_q, job_v_d;

  bp_cce_mem_msg_s           cmd;
  logic                      cmd_acc;
  logic                      is_rd, is_wr, hit;
  logic [7:0]                off;
  logic                      sel_start, sel_src, sel_len, sel_status, sel_cycles, mapped;
  logic                      start_req, cmd_err;
  logic [dword_width_lp-1:0] rd_data;
  logic                      unused_cmd_data;

  // Command decode against the 256-byte CSR window.
  assign cmd        = io.io_cmd_i;
  assign cmd_acc    = io.io_cmd_v_i & cmd_ready_q;
  assign is_rd      = (cmd.msg_type == e_cce_mem_uc_rd);
  assign is_wr      = (cmd.msg_type == e_cce_mem_uc_wr);
  assign hit        = (cmd.addr[paddr_width_lp-1:8] == csr_base_addr_p[paddr_width_lp-1:8])
                      && (cmd.addr[2:0] == 3'b000);
  assign off        = cmd.addr[7:0];
  assign sel_start  = hit && (off == start_off_lp);
  assign sel_src    = hit && (off == src_off_lp);
  assign sel_len    = hit && (off == len_off_lp);
  assign sel_status = hit && (off == status_off_lp);
  assign sel_cycles = hit && (off == cycles_off_lp);
  assign mapped     = sel_start | sel_src | sel_len | sel_status | sel_cycles;
  assign start_req  = is_wr & sel_start & cmd.data[0];
  assign cmd_err    = ~mapped
                      | ~(is_rd | is_wr)
                      | (is_wr & sel_cycles)
                      | (start_req & busy_q)
                      | (is_wr & (sel_src | sel_len) & busy_q);

  // Only the low physical-address bits of write data are meaningful.
  assign unused_cmd_data = ^cmd.data[block_width_lp-1:paddr_width_lp];

  // Read mux over pre-edge register values.
  always_comb begin
    rd_data = '0;
    if (sel_src) begin
      rd_data = dword_width_lp'(src_addr_q);
    end else if (sel_len) begin
      rd_data = dword_width_lp'(len_q);
    end else if (sel_status) begin
      rd_data = dword_width_lp'({err_q, done_q, busy_q});
    end else if (sel_cycles) begin
      rd_data = dword_width_lp'(cycles_q);
    end
  end

  // Next state: command handling first, then job progress so a done pulse wins over a W1C.
  always_comb begin
    state_d    = state_q;
    resp_d     = resp_q;
    resp_v_d   = resp_v_q;
    src_addr_d = src_addr_q;
    len_d      = len_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
    cycles_d   = cycles_q;
    job_v_d    = job_v_q;

    unique case (state_q)
      e_ready: begin
        if (cmd_acc) begin
          state_d     = e_resp;
          resp_v_d    = 1'b1;
          resp_d      = cmd;
          resp_d.data = '0;
          if (is_rd && !cmd_err) begin
            resp_d.data[dword_width_lp-1:0] = rd_data;
          end
          if (cmd_err) begin
            err_d = 1'b1;
          end else if (is_wr) begin
            if (sel_src) begin
              src_addr_d = cmd.data[paddr_width_lp-1:0];
            end
            if (sel_len) begin
              len_d = cmd.data[len_width_p-1:0];
            end
            if (sel_status) begin
              if (cmd.data[1]) done_d = 1'b0;
              if (cmd.data[2]) err_d  = 1'b0;
            end
            if (start_req) begin
              busy_d   = 1'b1;
              done_d   = 1'b0;
              cycles_d = '0;
              job_v_d  = 1'b1;
            end
          end
        end
      end
      e_resp: begin
        if (io.io_resp_yumi_i) begin
          state_d  = e_ready;
          resp_v_d = 1'b0;
        end
      end
      default: begin
        state_d = e_ready;
      end
    endcase

    if (busy_q) begin
      if (cycles_q != {cnt_width_p{1'b1}}) begin
        cycles_d = cycles_q + cnt_width_p'(1);
      end
      if (io.done_i) begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        job_v_d = 1'b0;
      end else if (job_v_q && io.job_ready_i) begin
        job_v_d = 1'b0;
      end
    end

    cmd_ready_d = (state_d == e_ready);
  end

  // State and CSR registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= e_ready;
      cmd_ready_q <= 1'b0;
      resp_q      <= '0;
      resp_v_q    <= 1'b0;
      src_addr_q  <= '0;
      len_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cycles_q    <= '0;
      job_v_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      resp_q      <= resp_d;
      resp_v_q    <= resp_v_d;
      src_addr_q  <= src_addr_d;
      len_q       <= len_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cycles_q    <= cycles_d;
      job_v_q     <= job_v_d;
    end
  end

  assign io.io_cmd_ready_o = cmd_ready_q;
  assign io.io_resp_o      = resp_q;
  assign io.io_resp_v_o    = resp_v_q;
  assign io.job_addr_o     = src_addr_q;
  assign io.job_len_o      = len_q;
  assign io.job_v_o        = job_v_q;
  assign io.busy_o         = busy_q;

endmodule

// File: tb/tb_bp_cac_io_csr_endpoint.sv
// Randomized scoreboard bench for the accelerator CSR endpoint.

module tb_bp_cac_io_csr_endpoint;
  import bp_cac_io_csr_endpoint_pkg::*;

  localparam int unsigned PW      = paddr_width_gp;
  localparam int unsigned LEN_W   = 16;
  localparam int unsigned CNT_W   = 4;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [PW-1:0] BASE  = 40'h00_0020_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bp_cac_io_csr_endpoint_if #(.len_width_p(LEN_W)) bus ();

  bp_cac_io_csr_endpoint #(
    .csr_base_addr_p(BASE),
    .len_width_p    (LEN_W),
    .cnt_width_p    (CNT_W)
  ) dut (
    .clk_i  (clk),
    .reset_i(rst),
    .io     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model of the CSR block.
  logic [PW-1:0]    m_src;
  logic [LEN_W-1:0] m_len;
  bit               m_busy, m_done, m_err, m_jv;
  int               m_cyc;
  bit               m_rstd, m_first;
  bp_cce_mem_msg_s  exp_q[$];

  // Datapath agent and stimulus state.
  int  k, jr_delay, done_delay;
  int  dir_jr   = -1;
  int  dir_done = -1;
  bit  force_done;
  bit  cmd_pend;
  bit  accepted_last;
  bp_cce_mem_msg_s cmd_cur;

  // Response consumer controls.
  int  stall;
  bit  hold_yumi;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit acc, input bp_cce_mem_msg_s c,
                            input bit d, input bit jr);
    bp_cce_mem_msg_s rsp;
    logic [63:0] rv;
    bit rd, wr, bad, launch, clr_done, clr_err, wr_src, wr_len;
    int idx;
    if (r) begin
      m_src = '0; m_len = '0; m_busy = 0; m_done = 0; m_err = 0; m_jv = 0; m_cyc = 0;
      exp_q.delete();
      k = 0;
      m_rstd = 1; m_first = 0;
      return;
    end
    m_first = m_rstd;
    m_rstd  = 0;
    rv = '0; bad = 0; launch = 0; clr_done = 0; clr_err = 0; wr_src = 0; wr_len = 0;
    if (acc) begin
      rd  = (c.msg_type == e_cce_mem_uc_rd);
      wr  = (c.msg_type == e_cce_mem_uc_wr);
      idx = -1;
      if (c.addr[PW-1:8] == BASE[PW-1:8] && (c.addr % 8) == 0 && c.addr[7:0] <= 8'h20)
        idx = int'(c.addr[7:0]) / 8;
      bad = (idx < 0) || !(rd || wr);
      case (idx)
        0: if (wr && c.data[0]) begin if (m_busy) bad = 1; else launch = 1; end
        1: begin rv = 64'(m_src); if (wr) begin if (m_busy) bad = 1; else wr_src = 1; end end
        2: begin rv = 64'(m_len); if (wr) begin if (m_busy) bad = 1; else wr_len = 1; end end
        3: begin
          rv = 64'({m_err, m_done, m_busy});
          if (wr) begin clr_done = c.data[1]; clr_err = c.data[2]; end
        end
        4: begin rv = 64'(m_cyc); if (wr) bad = 1; end
        default: ;
      endcase
      rsp = c;
      rsp.data = '0;
      if (rd && !bad) rsp.data[63:0] = rv;
      exp_q.push_back(rsp);
      if (bad) begin
        m_err = 1; launch = 0; wr_src = 0; wr_len = 0; clr_done = 0; clr_err = 0;
      end
    end
    if (wr_src)   m_src  = c.data[PW-1:0];
    if (wr_len)   m_len  = c.data[LEN_W-1:0];
    if (clr_err)  m_err  = 0;
    if (clr_done) m_done = 0;
    if (m_busy) begin
      if (m_cyc < CNT_MAX) m_cyc++;
      if (d) begin m_busy = 0; m_done = 1; m_jv = 0; end
      else if (m_jv && jr) m_jv = 0;
    end
    if (launch) begin m_busy = 1; m_done = 0; m_cyc = 0; m_jv = 1; end
  endtask

  // One clock: check outputs against the model, then drive inputs for the next edge.
  task automatic tick(input bit r);
    bit acc, d, jr, was_busy;
    @(negedge clk);
    if (accepted_last) check("resp_latency", 64'(bus.io_resp_v_o), 64'd1);
    accepted_last = 0;
    check("busy_o", 64'(bus.busy_o), 64'(m_busy));
    check("job_v_o", 64'(bus.job_v_o), 64'(m_jv));
    if (m_busy || m_rstd) begin
      check("job_addr_o", 64'(bus.job_addr_o), 64'(m_src));
      check("job_len_o", 64'(bus.job_len_o), 64'(m_len));
    end
    if (m_rstd) begin
      check("ready_in_reset", 64'(bus.io_cmd_ready_o), 64'd0);
      check("resp_v_in_reset", 64'(bus.io_resp_v_o), 64'd0);
    end
    if (m_first) check("ready_after_reset", 64'(bus.io_cmd_ready_o), 64'd1);

    if (m_busy) k++;
    d   = m_busy && (k == done_delay);
    jr  = (m_busy && (k > jr_delay)) || ($urandom % 8 == 0);
    acc = cmd_pend && !r && (bus.io_cmd_ready_o === 1'b1);
    if (!m_busy && ($urandom % 16 == 0)) d = 1;
    if (force_done && acc) begin d = 1; force_done = 0; end

    rst                = r;
    bus.io_cmd_v_i     = cmd_pend && !r;
    bus.io_cmd_i       = cmd_cur;
    bus.done_i         = d;
    bus.job_ready_i    = jr;

    was_busy = m_busy;
    model_step(r, acc, cmd_cur, d, jr);
    if (!was_busy && m_busy) begin
      k          = 0;
      jr_delay   = (dir_jr >= 0)   ? dir_jr   : $urandom_range(0, 5);
      done_delay = (dir_done >= 0) ? dir_done : $urandom_range(1, 25);
    end
    if (acc) begin cmd_pend = 0; accepted_last = 1; end
  endtask

  task automatic issue(input logic [3:0] t, input logic [PW-1:0] a, input logic [63:0] dl);
    cmd_cur          = '0;
    cmd_cur.data     = {16{$urandom}};
    cmd_cur.data[63:0] = dl;
    cmd_cur.payload  = 16'($urandom);
    cmd_cur.size     = 3'($urandom);
    cmd_cur.addr     = a;
    cmd_cur.msg_type = t;
    cmd_pend = 1;
    for (int i = 0; i < 80 && cmd_pend; i++) tick(0);
    if (cmd_pend) begin
      n_checks++; n_fail++;
      $display("FAIL cmd_accept_timeout: command at 0x%0h not accepted within 80 cycles", a);
      cmd_pend = 0;
    end
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 200; i++) begin
      tick(0);
      if (exp_q.size() == 0 && bus.io_resp_v_o === 1'b0) break;
    end
    if (i == 200) begin
      n_checks++; n_fail++;
      $display("FAIL idle_timeout: %0d responses still pending", exp_q.size());
    end
  endtask

  task automatic wait_job();
    int i;
    for (i = 0; i < 200 && m_busy; i++) tick(0);
    if (m_busy) begin
      n_checks++; n_fail++;
      $display("FAIL job_timeout: job still busy after 200 cycles");
    end
  endtask

  // Response monitor: compares every presented response against the scoreboard head.
  initial begin
    bus.io_resp_yumi_i = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst === 1'b0 && bus.io_resp_v_o === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL resp_unexpected: response at addr 0x%0h with empty scoreboard", bus.io_resp_o.addr);
        end else if (bus.io_resp_o !== exp_q[0]) begin
          n_fail++;
          $display("FAIL resp: got type %0h addr %0h size %0h pl %0h data %0h, expected type %0h addr %0h size %0h pl %0h data %0h",
                   bus.io_resp_o.msg_type, bus.io_resp_o.addr, bus.io_resp_o.size, bus.io_resp_o.payload,
                   bus.io_resp_o.data[63:0], exp_q[0].msg_type, exp_q[0].addr, exp_q[0].size,
                   exp_q[0].payload, exp_q[0].data[63:0]);
        end
        check("ready_while_resp", 64'(bus.io_cmd_ready_o), 64'd0);
        if (hold_yumi || stall > 0) begin
          if (stall > 0) stall--;
          bus.io_resp_yumi_i = 1'b0;
        end else begin
          bus.io_resp_yumi_i = ($urandom % 3 != 0);
        end
        if (bus.io_resp_yumi_i && exp_q.size() > 0) void'(exp_q.pop_front());
      end else begin
        bus.io_resp_yumi_i = 1'b0;
      end
    end
  end

  // Stimulus.
  initial begin
    logic [3:0]    t;
    logic [PW-1:0] a;
    logic [63:0]   dl;
    rst = 1'b1;
    bus.io_cmd_v_i = 1'b0; bus.io_cmd_i = '0; bus.done_i = 1'b0; bus.job_ready_i = 1'b0;
    cmd_cur = '0; cmd_pend = 0; force_done = 0; accepted_last = 0; stall = 0; hold_yumi = 0;
    m_src = '0; m_len = '0; m_busy = 0; m_done = 0; m_err = 0; m_jv = 0; m_cyc = 0;
    m_rstd = 0; m_first = 0; k = 0; jr_delay = 0; done_delay = 0;

    repeat (3) tick(1);
    tick(0);

    // Register write / read-back.
    issue(e_cce_mem_uc_wr, BASE + 40'h08, 64'h0000_0000_8000_0040);
    issue(e_cce_mem_uc_wr, BASE + 40'h10, 64'h4);
    issue(e_cce_mem_uc_rd, BASE + 40'h08, 64'h0);
    issue(e_cce_mem_uc_rd, BASE + 40'h10, 64'h0);

    // Timed job: ready after 3 cycles, done 10 cycles after launch.
    dir_jr = 3; dir_done = 10;
    issue(e_cce_mem_uc_wr, BASE, 64'h1);
    wait_job();
    issue(e_cce_mem_uc_rd, BASE + 40'h18, 64'h0);
    issue(e_cce_mem_uc_rd, BASE + 40'h20, 64'h0);

    // Second START while busy, then W1C of err.
    dir_done = 40;
    issue(e_cce_mem_uc_wr, BASE, 64'h1);
    issue(e_cce_mem_uc_wr, BASE, 64'h1);
    wait_job();
    issue(e_cce_mem_uc_rd, BASE + 40'h18, 64'h0);
    issue(e_cce_mem_uc_wr, BASE + 40'h18, 64'h4);
    issue(e_cce_mem_uc_rd, BASE + 40'h18, 64'h0);

    // Error cases, first one with a stalled response.
    wait_idle();
    stall = 5;
    issue(e_cce_mem_uc_rd, BASE + 40'h28, 64'h0);
    issue(e_cce_mem_uc_rd, 40'h00_0030_0000, 64'h0);
    issue(e_cce_mem_uc_wr, BASE + 40'h20, 64'h7);
    issue(e_cce_mem_rd, BASE + 40'h08, 64'h0);
    issue(e_cce_mem_uc_rd, BASE + 40'h09, 64'h0);
    issue(e_cce_mem_uc_rd, BASE + 40'h18, 64'h0);
    issue(e_cce_mem_uc_wr, BASE + 40'h18, 64'h6);

    // done_i coinciding with a done W1C, then with a START.
    dir_done = 60;
    issue(e_cce_mem_uc_wr, BASE, 64'h1);
    force_done = 1;
    issue(e_cce_mem_uc_wr, BASE + 40'h18, 64'h2);
    issue(e_cce_mem_uc_rd, BASE + 40'h18, 64'h0);
    issue(e_cce_mem_uc_wr, BASE, 64'h1);
    force_done = 1;
    issue(e_cce_mem_uc_wr, BASE, 64'h1);
    issue(e_cce_mem_uc_rd, BASE + 40'h18, 64'h0);

    // Counter saturation on a 20-cycle job.
    dir_jr = 0; dir_done = 20;
    issue(e_cce_mem_uc_wr, BASE, 64'h1);
    wait_job();
    issue(e_cce_mem_uc_rd, BASE + 40'h20, 64'h0);

    // Reset while a response is pending and a job is running.
    dir_done = 80;
    issue(e_cce_mem_uc_wr, BASE, 64'h1);
    wait_idle();
    hold_yumi = 1;
    issue(e_cce_mem_uc_rd, BASE + 40'h10, 64'h0);
    repeat (3) tick(0);
    tick(1);
    hold_yumi = 0;
    tick(0);
    issue(e_cce_mem_uc_rd, BASE + 40'h08, 64'h0);
    issue(e_cce_mem_uc_rd, BASE + 40'h10, 64'h0);
    issue(e_cce_mem_uc_rd, BASE + 40'h18, 64'h0);
    issue(e_cce_mem_uc_rd, BASE + 40'h20, 64'h0);

    // Randomized traffic.
    dir_jr = -1; dir_done = -1;
    for (int n = 0; n < 400; n++) begin
      case ($urandom % 10)
        7:       a = BASE + 40'h28;
        8:       a = BASE + PW'($urandom_range(1, 7)) + 40'h08 * PW'($urandom_range(0, 4));
        9:       a = 40'h00_0030_0000 + PW'($urandom_range(0, 4) * 8);
        default: a = BASE + 40'h08 * PW'($urandom_range(0, 4));
      endcase
      if ($urandom % 8 == 0) t = 4'($urandom);
      else t = ($urandom % 2 == 0) ? e_cce_mem_uc_rd : e_cce_mem_uc_wr;
      dl = {$urandom, $urandom};
      issue(t, a, dl);
      if ($urandom % 150 == 0) tick(1);
      if ($urandom % 10 == 0) repeat ($urandom_range(1, 6)) tick(0);
    end
    wait_idle();
    wait_job();
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
